// File: rtl/legv8_pkg.sv
// Shared LEGv8 opcode constants, ALU control codes and sequencer enums.
// Used by the ALU op sequencer and the immediate generator.
package legv8_pkg;

    localparam logic [10:0] OP_ADD  = 11'b10001011000;
    localparam logic [10:0] OP_SUB  = 11'b11001011000;
    localparam logic [10:0] OP_AND  = 11'b10001010000;
    localparam logic [10:0] OP_ORR  = 11'b10101010000;
    localparam logic [10:0] OP_EOR  = 11'b11001010000;
    localparam logic [10:0] OP_LDUR = 11'b11111000010;
    localparam logic [10:0] OP_STUR = 11'b11111000000;
    localparam logic [8:0]  OP_MOVZ = 9'b110100101;
    localparam logic [7:0]  OP_CBZ  = 8'b10110100;
    localparam logic [7:0]  OP_CBNZ = 8'b10110101;

    localparam logic [3:0] ALU_NOP  = 4'b0000;
    localparam logic [3:0] ALU_ADD  = 4'b0010;
    localparam logic [3:0] ALU_SUB  = 4'b1010;
    localparam logic [3:0] ALU_AND  = 4'b0110;
    localparam logic [3:0] ALU_ORR  = 4'b0100;
    localparam logic [3:0] ALU_EOR  = 4'b1001;
    localparam logic [3:0] ALU_MOVZ = 4'b1101;
    localparam logic [3:0] ALU_CBZ  = 4'b0111;
    localparam logic [3:0] ALU_CBNZ = 4'b0001;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_DECODE,
        ST_EXEC,
        ST_WB,
        ST_MEM,
        ST_MEM_WAIT,
        ST_BR,
        ST_ILLEGAL
    } seq_state_e;

    typedef enum logic [2:0] {
        CLS_NONE,
        CLS_RTYPE,
        CLS_MOVZ,
        CLS_LOAD,
        CLS_STORE,
        CLS_CB
    } instr_class_e;

endpackage

// File: rtl/legv8_imm_gen.sv
// Combinational immediate extractor for the LEGv8 D, IM and CB formats.
// Takes Instr[23:5], which covers every immediate field of those formats.
module legv8_imm_gen
    import legv8_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic [23:5]       imm_bits,
    output logic [DATA_W-1:0] d_imm,
    output logic [DATA_W-1:0] im_imm,
    output logic [DATA_W-1:0] cb_offset
);

    logic [DATA_W-1:0] cb_sext;

    assign d_imm     = {{(DATA_W-9){imm_bits[20]}}, imm_bits[20:12]};
    assign im_imm    = {{(DATA_W-16){1'b0}}, imm_bits[20:5]};
    assign cb_sext   = {{(DATA_W-19){imm_bits[23]}}, imm_bits[23:5]};
    // Word offset to byte offset; the top two bits fall off so it wraps at DATA_W.
    assign cb_offset = {cb_sext[DATA_W-3:0], 2'b00};

endmodule

// File: rtl/alu_op_sequencer.sv
// Multi-cycle LEGv8 control sequencer: decodes one instruction per handshake,
// steers the ALU, then retires it as a write-back, memory access or branch.
module alu_op_sequencer
    import legv8_pkg::*;
#(
    parameter int DATA_W      = 32,
    parameter int MEM_TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [31:0]       Instr,
    input  logic              Instr_valid,
    output logic              Instr_ready,
    output logic [4:0]        Rn_addr,
    output logic [4:0]        Rm_addr,
    output logic [4:0]        Rd_addr,
    output logic [3:0]        ALU_control,
    output logic              ALUSrc,
    output logic [DATA_W-1:0] Sign_extend,
    input  logic [DATA_W-1:0] ALU_Result,
    input  logic              Zero,
    output logic              Reg_write,
    output logic [DATA_W-1:0] Wb_data,
    output logic [DATA_W-1:0] Mem_addr,
    output logic              Mem_read,
    output logic              Mem_write,
    input  logic [DATA_W-1:0] Mem_rdata,
    input  logic              Mem_rvalid,
    output logic              Branch_taken,
    output logic [DATA_W-1:0] Branch_offset,
    output logic              Done,
    output logic              Illegal,
    output logic              Mem_err
);

    localparam int CNT_W = $clog2(MEM_TIMEOUT + 1);

    seq_state_e        state, next_state;
    instr_class_e      dec_cls, cls_q;
    logic [3:0]        dec_alu_ctrl, alu_ctrl_q;
    logic              dec_alu_src, alu_src_q;
    logic [DATA_W-1:0] dec_sext, sext_q;
    logic [DATA_W-1:0] br_off_q, result_q;
    logic              zero_q;
    logic [4:0]        rn_q, rm_q, rd_q;
    logic [CNT_W-1:0]  wait_cnt;
    logic [DATA_W-1:0] d_imm, im_imm, cb_off;
    logic              accept;

    assign accept = Instr_valid & Instr_ready;

    legv8_imm_gen #(.DATA_W(DATA_W)) u_imm_gen (
        .imm_bits  (Instr[23:5]),
        .d_imm     (d_imm),
        .im_imm    (im_imm),
        .cb_offset (cb_off)
    );

    // Decoding the incoming word lets the registered controls be valid during DECODE.
    always_comb begin
        dec_cls      = CLS_NONE;
        dec_alu_ctrl = ALU_NOP;
        dec_alu_src  = 1'b0;
        dec_sext     = '0;
        if (Instr[31:21] == OP_ADD) begin
            dec_cls      = CLS_RTYPE;
            dec_alu_ctrl = ALU_ADD;
        end else if (Instr[31:21] == OP_SUB) begin
            dec_cls      = CLS_RTYPE;
            dec_alu_ctrl = ALU_SUB;
        end else if (Instr[31:21] == OP_AND) begin
            dec_cls      = CLS_RTYPE;
            dec_alu_ctrl = ALU_AND;
        end else if (Instr[31:21] == OP_ORR) begin
            dec_cls      = CLS_RTYPE;
            dec_alu_ctrl = ALU_ORR;
        end else if (Instr[31:21] == OP_EOR) begin
            dec_cls      = CLS_RTYPE;
            dec_alu_ctrl = ALU_EOR;
        end else if (Instr[31:21] == OP_LDUR || Instr[31:21] == OP_STUR) begin
            dec_cls      = (Instr[31:21] == OP_LDUR) ? CLS_LOAD : CLS_STORE;
            dec_alu_ctrl = ALU_ADD;
            dec_alu_src  = 1'b1;
            dec_sext     = d_imm;
        end else if (Instr[31:23] == OP_MOVZ) begin
            dec_cls      = CLS_MOVZ;
            dec_alu_ctrl = ALU_MOVZ;
            dec_alu_src  = 1'b1;
            dec_sext     = im_imm;
        end else if (Instr[31:24] == OP_CBZ || Instr[31:24] == OP_CBNZ) begin
            dec_cls      = CLS_CB;
            dec_alu_ctrl = (Instr[31:24] == OP_CBZ) ? ALU_CBZ : ALU_CBNZ;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= ST_IDLE;
            cls_q      <= CLS_NONE;
            alu_ctrl_q <= ALU_NOP;
            alu_src_q  <= 1'b0;
            sext_q     <= '0;
            br_off_q   <= '0;
            rn_q       <= '0;
            rm_q       <= '0;
            rd_q       <= '0;
            result_q   <= '0;
            zero_q     <= 1'b0;
            wait_cnt   <= '0;
        end else begin
            state <= next_state;
            if (accept) begin
                cls_q      <= dec_cls;
                alu_ctrl_q <= dec_alu_ctrl;
                alu_src_q  <= dec_alu_src;
                sext_q     <= dec_sext;
                br_off_q   <= cb_off;
                rn_q       <= (dec_cls == CLS_CB) ? Instr[4:0] : Instr[9:5];
                rm_q       <= Instr[20:16];
                rd_q       <= Instr[4:0];
            end
            if (state == ST_EXEC) begin
                result_q <= ALU_Result;
                zero_q   <= Zero;
            end
            if (state == ST_MEM) begin
                wait_cnt <= '0;
            end else if (state == ST_MEM_WAIT && !Mem_rvalid) begin
                wait_cnt <= wait_cnt + CNT_W'(1);
            end
        end
    end

    assign Rn_addr = rn_q;
    assign Rm_addr = rm_q;
    assign Rd_addr = rd_q;

    always_comb begin
        next_state    = state;
        Instr_ready   = 1'b0;
        ALU_control   = alu_ctrl_q;
        ALUSrc        = alu_src_q;
        Sign_extend   = sext_q;
        Reg_write     = 1'b0;
        Wb_data       = '0;
        Mem_addr      = '0;
        Mem_read      = 1'b0;
        Mem_write     = 1'b0;
        Branch_taken  = 1'b0;
        Branch_offset = '0;
        Done          = 1'b0;
        Illegal       = 1'b0;
        Mem_err       = 1'b0;
        case (state)
            ST_IDLE: begin
                Instr_ready = 1'b1;
                ALU_control = ALU_NOP;
                ALUSrc      = 1'b0;
                Sign_extend = '0;
                if (Instr_valid) next_state = ST_DECODE;
            end
            ST_DECODE: begin
                next_state = (cls_q == CLS_NONE) ? ST_ILLEGAL : ST_EXEC;
            end
            ST_ILLEGAL: begin
                Illegal    = 1'b1;
                next_state = ST_IDLE;
            end
            ST_EXEC: begin
                case (cls_q)
                    CLS_RTYPE, CLS_MOVZ: next_state = ST_WB;
                    CLS_LOAD, CLS_STORE: next_state = ST_MEM;
                    CLS_CB:              next_state = ST_BR;
                    default:             next_state = ST_IDLE;
                endcase
            end
            ST_WB: begin
                Reg_write  = 1'b1;
                Wb_data    = result_q;
                Done       = 1'b1;
                next_state = ST_IDLE;
            end
            ST_MEM: begin
                Mem_addr = result_q;
                if (cls_q == CLS_STORE) begin
                    Mem_write  = 1'b1;
                    Done       = 1'b1;
                    next_state = ST_IDLE;
                end else begin
                    Mem_read   = 1'b1;
                    next_state = ST_MEM_WAIT;
                end
            end
            ST_MEM_WAIT: begin
                Mem_addr = result_q;
                if (Mem_rvalid) begin
                    Reg_write  = 1'b1;
                    Wb_data    = Mem_rdata;
                    Done       = 1'b1;
                    next_state = ST_IDLE;
                end else if (wait_cnt == CNT_W'(MEM_TIMEOUT - 1)) begin
                    Mem_err    = 1'b1;
                    next_state = ST_IDLE;
                end
            end
            ST_BR: begin
                Branch_taken  = zero_q;
                Branch_offset = br_off_q;
                Done          = 1'b1;
                next_state    = ST_IDLE;
            end
            default: next_state = ST_IDLE;
        endcase
    end

endmodule
